ase_umsg_scheduler: RTL
=======================

// Module: ase_umsg_scheduler
// PURPOSE
// - Sequences unordered messages (UMsgs) from the ASE UMsg command path onto the AFU RX0 channel.
// - Holds one slot per UMsg id, each running its own FSM: Idle -> SendHint -> Waiting -> SendData.
// - Timers set the hint and data delays for each slot.
// - A round-robin arbiter shares the single registered output among slots; the RX0 mux downstream backpressures it.
// PARAMETERS
// NUM_UMSG    8    number of UMsg slots (ids 0..NUM_UMSG-1), power of 2, <=64
// DATA_WIDTH  512  UMsg payload width (CCIP_DATA_WIDTH)
// TIMER_W     8    hint/data timer width (UMSG_DELAY_TIMER_LOG2)
// HINT_DELAY  4    cycles from accept to hint request, < 2**TIMER_W
// DATA_DELAY  16   cycles from entering Waiting to data request, < 2**TIMER_W
// PORTS
// clk         in   1                  clock
// rst_n       in   1                  synchronous reset, active low
// cmd_valid   in   1                  UMsg command present
// cmd_ready   out  1                  command accepted this cycle; comb = (slot[cmd_id]==Idle) && rst_n
// cmd_id      in   $clog2(NUM_UMSG)   target slot
// cmd_hint    in   1                  1: send hint before data
// cmd_data    in   DATA_WIDTH         payload
// umsg_valid  out  1                  output UMsg valid (registered)
// umsg_ready  in   1                  RX0 mux takes output
// umsg_hint   out  1                  1=hint (UMsgHdr umsg_type=1), 0=data
// umsg_id     out  6                  UMsgHdr umsg_id, zero-extended slot index
// umsg_data   out  DATA_WIDTH         payload; all-zero for hints
// slot_busy   out  NUM_UMSG           per-slot state != Idle
// BEHAVIOUR
// - Reset (rst_n=0 at edge): all slots Idle, timers 0, RR pointer 0; umsg_valid/hint/id/data=0, slot_busy=0.
// - Reset mid-operation discards pending UMsgs and drops umsg_valid on the same edge.
// - Accept = cmd_valid && cmd_ready. Payload latched into the slot.
//   - cmd_hint=1: ->SendHint, hint_timer=HINT_DELAY.
//   - cmd_hint=0: ->Waiting, data_timer=DATA_DELAY.
// - A busy slot keeps cmd_ready low. The command is stalled, never dropped or overwritten.
// - SendHint: timer!=0 -> decrement. timer==0 -> raise hint request.
//   - On grant edge -> Waiting, data_timer=DATA_DELAY.
// - Waiting: timer!=0 -> decrement; timer==0 -> SendData on the next edge.
// - SendData: raise data request. On grant edge -> Idle, and slot_busy clears the next cycle.
// - Output load: when (!umsg_valid || umsg_ready) and any request is up, the RR winner is loaded and granted on that edge.
//   - Search starts at ptr. ptr <= winner+1 mod NUM_UMSG.
//   - If nothing loads and umsg_ready=1, umsg_valid drops to 0.
// - While umsg_valid && !umsg_ready: outputs held stable, no grants, and slots still requesting stay requesting.
//   - Timers of non-requesting slots keep running.
// - Latency with no contention, umsg_ready=1:
//   - No-hint: umsg_valid (data) is high in cycle DATA_DELAY+2 after the accept edge.
//   - Hint: hint in cycle HINT_DELAY+1, then data in cycle HINT_DELAY+DATA_DELAY+3.
// - Delay 0 is legal: the timer is already 0 and the request or transition happens on the next edge.
// - Timers never wrap: decrement only when !=0.
// - Accept on slot X cannot coincide with a grant to X (X is not Idle). After the grant edge X reads Idle and may accept the next cycle.
// - Hint and data requests have equal priority; order is purely round-robin.
// TESTING
// - Reset, cmd id=3, hint=0, data=0xA5.. -> umsg_valid in cycle 18 (D=16); id=3, hint=0, data=0xA5..; slot_busy[3] clears after.
// - Cmd id=5, hint=1 -> hint id=5, data=0 in cycle 5, then data in cycle 23; one beat each.
// - Slot 2 busy, cmd id=2 held valid -> cmd_ready=0 until the data beat is granted; accepted next cycle with no loss.
// - Slots 0,1,7 all reach SendData in the same cycle -> beats in RR order 0,1,7. A repeat with ptr=1 gives 1,7,0.
// - Hold umsg_ready=0 for 10 cycles with a beat pending -> output stable; on release, the beat is taken and the next is loaded the same edge.
// - Reset asserted while slots are in Waiting and umsg_valid=1 -> next cycle all zero; no stale UMsg appears afterwards.

Source files
------------

// File: rtl/ase_umsg_scheduler_if.sv
// ase_umsg_scheduler_if
//   Groups the UMsg command path (ASE side) and the RX0 UMsg output path
//   of ase_umsg_scheduler.
//   cmd_valid/cmd_ready/cmd_id/cmd_hint/cmd_data : command handshake into the scheduler
//   umsg_valid/umsg_ready/umsg_hint/umsg_id/umsg_data : registered UMsg output towards RX0 mux
//   modport slave  : scheduler side
//   modport master : command source / RX0 consumer side
interface ase_umsg_scheduler_if #(
  parameter int NUM_UMSG   = 8,
  parameter int DATA_WIDTH = 512
);
  localparam int ID_W = (NUM_UMSG > 1) ? $clog2(NUM_UMSG) : 1;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ID_W-1:0]       cmd_id;
  logic                  cmd_hint;
  logic [DATA_WIDTH-1:0] cmd_data;

  logic                  umsg_valid;
  logic                  umsg_ready;
  logic                  umsg_hint;
  logic [5:0]            umsg_id;
  logic [DATA_WIDTH-1:0] umsg_data;

  modport slave (
    input  cmd_valid, cmd_id, cmd_hint, cmd_data, umsg_ready,
    output cmd_ready, umsg_valid, umsg_hint, umsg_id, umsg_data
  );

  modport master (
    output cmd_valid, cmd_id, cmd_hint, cmd_data, umsg_ready,
    input  cmd_ready, umsg_valid, umsg_hint, umsg_id, umsg_data
  );
endinterface

// File: rtl/ase_umsg_scheduler.sv
// ase_umsg_scheduler
//   Sequences UMsgs from the ASE command path onto the AFU RX0 channel.
//   One slot per UMsg id, each stepping Idle -> SendHint -> Waiting -> SendData,
//   with a per-slot delay timer. A round-robin arbiter loads one requesting slot
//   at a time into a single registered output stage that the RX0 mux backpressures.
//   Ports:
//     clk       : clock
//     rst_n     : synchronous reset, active low
//     umsg_if   : command input and UMsg output handshakes (slave modport)
//     slot_busy : per-slot "state != Idle"
module ase_umsg_scheduler #(
  parameter int NUM_UMSG   = 8,
  parameter int DATA_WIDTH = 512,
  parameter int TIMER_W    = 8,
  parameter int HINT_DELAY = 4,
  parameter int DATA_DELAY = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  ase_umsg_scheduler_if.slave umsg_if,
  output logic [NUM_UMSG-1:0] slot_busy
);

  localparam int ID_W = (NUM_UMSG > 1) ? $clog2(NUM_UMSG) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND_HINT,
    S_WAITING,
    S_SEND_DATA
  } slot_state_t;

  slot_state_t           state_q   [NUM_UMSG];
  slot_state_t           state_d   [NUM_UMSG];
  logic [TIMER_W-1:0]    timer_q   [NUM_UMSG];
  logic [TIMER_W-1:0]    timer_d   [NUM_UMSG];
  logic [DATA_WIDTH-1:0] payload_q [NUM_UMSG];

  logic [NUM_UMSG-1:0]   req;
  logic [NUM_UMSG-1:0]   grant;
  logic                  accept;
  logic                  load_en;
  logic                  win_found;
  logic [ID_W-1:0]       win_idx;
  logic [ID_W-1:0]       cand;
  logic [ID_W-1:0]       rr_ptr_q;

  logic                  valid_q;
  logic                  hint_q;
  logic [5:0]            id_q;
  logic [DATA_WIDTH-1:0] data_q;

  // ---------------------------------------------------------------------------
  // Command handshake
  // ---------------------------------------------------------------------------
  assign umsg_if.cmd_ready = (state_q[umsg_if.cmd_id] == S_IDLE) && rst_n;
  assign accept            = umsg_if.cmd_valid && umsg_if.cmd_ready;

  // ---------------------------------------------------------------------------
  // Per-slot requests and busy flags
  // ---------------------------------------------------------------------------
  always_comb begin
    req       = '0;
    slot_busy = '0;
    for (int unsigned i = 0; i < NUM_UMSG; i++) begin
      req[i]       = ((state_q[i] == S_SEND_HINT) && (timer_q[i] == '0)) ||
                     (state_q[i] == S_SEND_DATA);
      slot_busy[i] = (state_q[i] != S_IDLE);
    end
  end

  // ---------------------------------------------------------------------------
  // Round-robin arbiter: first requester at or after rr_ptr_q, wrapping.
  // NUM_UMSG is a power of two, so the ID_W-bit add wraps modulo NUM_UMSG.
  // ---------------------------------------------------------------------------
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned off = 0; off < NUM_UMSG; off++) begin
      cand = rr_ptr_q + ID_W'(off);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Loading the output register is the grant: the slot advances on that edge
  // even though the beat may then sit in the register under backpressure.
  assign load_en = (!valid_q || umsg_if.umsg_ready) && win_found;

  always_comb begin
    grant = '0;
    if (load_en) begin
      grant[win_idx] = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Slot FSMs: next-state and timers
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int unsigned i = 0; i < NUM_UMSG; i++) begin
      state_d[i] = state_q[i];
      timer_d[i] = timer_q[i];
      unique case (state_q[i])
        S_IDLE: begin
          if (accept && (umsg_if.cmd_id == ID_W'(i))) begin
            if (umsg_if.cmd_hint) begin
              state_d[i] = S_SEND_HINT;
              timer_d[i] = TIMER_W'(HINT_DELAY);
            end else begin
              state_d[i] = S_WAITING;
              timer_d[i] = TIMER_W'(DATA_DELAY);
            end
          end
        end
        S_SEND_HINT: begin
          if (timer_q[i] != '0) begin
            timer_d[i] = timer_q[i] - 1'b1;
          end else if (grant[i]) begin
            state_d[i] = S_WAITING;
            timer_d[i] = TIMER_W'(DATA_DELAY);
          end
        end
        S_WAITING: begin
          if (timer_q[i] != '0) begin
            timer_d[i] = timer_q[i] - 1'b1;
          end else begin
            state_d[i] = S_SEND_DATA;
          end
        end
        S_SEND_DATA: begin
          if (grant[i]) begin
            state_d[i] = S_IDLE;
          end
        end
        default: begin
          state_d[i] = S_IDLE;
          timer_d[i] = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_UMSG; i++) begin
        state_q[i] <= S_IDLE;
        timer_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_UMSG; i++) begin
        state_q[i] <= state_d[i];
        timer_q[i] <= timer_d[i];
      end
    end
  end

  // Payload storage is not reset: it is only read after an accept has
  // overwritten it, and accept is already gated by rst_n through cmd_ready.
  always_ff @(posedge clk) begin
    if (accept) begin
      payload_q[umsg_if.cmd_id] <= umsg_if.cmd_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered output stage and RR pointer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      hint_q   <= 1'b0;
      id_q     <= '0;
      data_q   <= '0;
      rr_ptr_q <= '0;
    end else if (load_en) begin
      valid_q  <= 1'b1;
      hint_q   <= (state_q[win_idx] == S_SEND_HINT);
      id_q     <= 6'(win_idx);
      data_q   <= (state_q[win_idx] == S_SEND_HINT) ? '0 : payload_q[win_idx];
      rr_ptr_q <= win_idx + 1'b1;
    end else if (umsg_if.umsg_ready) begin
      valid_q  <= 1'b0;
    end
  end

  assign umsg_if.umsg_valid = valid_q;
  assign umsg_if.umsg_hint  = hint_q;
  assign umsg_if.umsg_id    = id_q;
  assign umsg_if.umsg_data  = data_q;

endmodule
